// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator bank meter.
// Contents: the measurement FSM state type, the synchroniser depth, and a
// clog2 helper that never returns less than 1. The helper sizes select
// ports, so a single-ring build still gets a 1-bit select.
`timescale 1ns/1ps
package ro_meter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    localparam int SYNC_STAGES = 2;

    function automatic int clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ro_ring.sv
// One enable-gated ring oscillator with a ripple prescaler.
// Ports:
//   rst_n    in   async active-low reset for the prescaler
//   enable   in   NAND enable; low forces the ring to a static level
//   osc_raw  out  raw ring output (last stage)
//   osc_div  out  ring output divided by 2**DIV_LOG2 (osc_raw when DIV_LOG2=0)
// Parameters: STAGES (odd, >=3), DIV_LOG2, STAGE_DLY (simulation-only stage delay in ns).
`timescale 1ns/1ps
module ro_ring #(
    parameter int STAGES    = 5,
    parameter int DIV_LOG2  = 2,
    parameter int STAGE_DLY = 1
) (
    input  logic rst_n,
    input  logic enable,
    output logic osc_raw,
    output logic osc_div
);

    logic [STAGES-1:0] node;
    logic [DIV_LOG2:0] tap;
    logic              clr_n;

`ifndef SYNTHESIS
    // Level every stage settles to while the NAND enable is low: the NAND
    // output is 1 and the inverters alternate from there.
    function automatic logic [STAGES-1:0] rest_level();
        logic [STAGES-1:0] v;
        for (int i = 0; i < STAGES; i++) begin
            v[i] = (i % 2 == 0);
        end
        return v;
    endfunction

    localparam logic [STAGES-1:0] REST = rest_level();

    // Behavioural ring: every STAGE_DLY each stage takes the value its
    // gate would drive from the previous stage. Starting from the rest
    // level guarantees a single edge circulates, giving a period of
    // 2*STAGES*STAGE_DLY.
    always begin : ring_model
        if (!enable) begin
            node = REST;
            @(posedge enable);
        end else begin
            #STAGE_DLY;
            node = ~{node[STAGES-2:0], enable & node[STAGES-1]};
        end
    end
`else
    assign node[0] = ~(enable & node[STAGES-1]);
    for (genvar s = 1; s < STAGES; s++) begin : g_inv
        assign node[s] = ~node[s-1];
    end
`endif

    assign osc_raw = node[STAGES-1];

    // The prescaler is cleared while the ring is disabled, so each
    // measurement starts from the same divider phase.
    assign clr_n  = rst_n & enable;
    assign tap[0] = osc_raw;

    for (genvar d = 0; d < DIV_LOG2; d++) begin : g_div
        logic q;
        always_ff @(posedge tap[d] or negedge clr_n) begin
            if (!clr_n) begin
                q <= 1'b0;
            end else begin
                q <= ~q;
            end
        end
        assign tap[d+1] = q;
    end

    assign osc_div = tap[DIV_LOG2];

endmodule

// File: rtl/ro_bank_meter.sv
// Bank of NUM_RO ring oscillators with a gated edge-counting frequency meter.
// A start in IDLE latches sel/gate_cycles, enables ring[sel], waits SETTLE
// cycles, then counts synchronised rising edges of the prescaled ring for
// gate_cycles clk cycles. The count saturates and flags overflow.
// Ports:
//   clk, rst_n    system clock, async active-low reset (release is expected
//                 to be synchronised by the pin wrapper)
//   start         1-cycle request, accepted only in IDLE
//   sel           ring select, latched on accepted start
//   gate_cycles   gate window in clk cycles, latched on accepted start
//   cont          continuous re-measure (only when RO_CONT_EN is defined)
//   busy          high from accepted start through the done cycle
//   done          1-cycle pulse; count/overflow valid from this cycle
//   count         prescaled edges seen in the last gate window
//   overflow      count saturated during the last window
//   osc_out       raw output of the enabled ring, 0 when none is enabled
// Build option: define RO_CONT_EN to add the cont port and continuous mode.
`timescale 1ns/1ps
module ro_bank_meter
    import ro_meter_pkg::*;
#(
    parameter int NUM_RO   = 4,
    parameter int STAGES   = 5,
    parameter int DIV_LOG2 = 2,
    parameter int GATE_W   = 16,
    parameter int CNT_W    = 16,
    parameter int SETTLE   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [clog2(NUM_RO)-1:0]  sel,
    input  logic [GATE_W-1:0]         gate_cycles,
`ifdef RO_CONT_EN
    input  logic                      cont,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          count,
    output logic                      overflow,
    output logic                      osc_out
);

    localparam int SEL_W = clog2(NUM_RO);
    localparam int SET_W = clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                  state, next_state;
    logic [SEL_W-1:0]        sel_q;
    logic [GATE_W-1:0]       gate_q;
    logic [GATE_W-1:0]       gate_cnt;
    logic [SET_W-1:0]        settle_cnt;
    logic                    ring_on;
    logic [NUM_RO-1:0]       ring_en;
    logic [NUM_RO-1:0]       osc_raw;
    logic [NUM_RO-1:0]       osc_div;
    logic                    osc_sel;
    logic [SYNC_STAGES-1:0]  sync;
    logic                    sync_prev;
    logic                    rise;
    logic                    cont_now;

`ifdef RO_CONT_EN
    assign cont_now = cont;
`else
    assign cont_now = 1'b0;
`endif

    for (genvar i = 0; i < NUM_RO; i++) begin : g_ring
        assign ring_en[i] = ring_on && ((NUM_RO == 1) || (sel_q == SEL_W'(i)));
        ro_ring #(
            .STAGES   (STAGES),
            .DIV_LOG2 (DIV_LOG2)
        ) u_ring (
            .rst_n   (rst_n),
            .enable  (ring_en[i]),
            .osc_raw (osc_raw[i]),
            .osc_div (osc_div[i])
        );
    end

    // Disabled rings are gated off here and their prescalers sit in reset,
    // so OR-reducing is a select without an out-of-range index.
    assign osc_out = |(osc_raw & ring_en);
    assign osc_sel = |(osc_div & ring_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync      <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], osc_sel};
            sync_prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~sync_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = ARM;
            ARM:  if (settle_cnt == '0) next_state = (gate_q == '0) ? DONE : GATE;
            GATE: if (gate_cnt == '0) next_state = DONE;
            DONE: next_state = (cont_now && (gate_q != '0)) ? GATE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // In continuous mode the ring stays on through DONE so the next window
    // reuses the running oscillator without re-settling.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        ring_on = (state == ARM) || (state == GATE) ||
                  ((state == DONE) && (next_state == GATE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q      <= '0;
            gate_q     <= '0;
            gate_cnt   <= '0;
            settle_cnt <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q      <= sel;
                        gate_q     <= gate_cycles;
                        settle_cnt <= SET_W'(SETTLE - 1);
                        count      <= '0;
                        overflow   <= 1'b0;
                    end
                end
                ARM: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end else begin
                        gate_cnt <= gate_q - GATE_W'(1);
                    end
                end
                GATE: begin
                    if (rise) begin
                        if (count == CNT_MAX) begin
                            overflow <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
                    if (gate_cnt != '0) begin
                        gate_cnt <= gate_cnt - GATE_W'(1);
                    end
                end
                DONE: begin
                    if (next_state == GATE) begin
                        gate_cnt <= gate_q - GATE_W'(1);
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_bank_meter.sv
// Directed self-checking bench for ro_bank_meter.
// Two instances share stimulus: dut (CNT_W=16) for the main results and
// dut8 (CNT_W=8) for saturation. clk 20 ns, ring 100 MHz, prescaled 25 MHz,
// so a window of G clk cycles holds G/2 prescaled edges.
// Latency is counted in clk cycles from the start cycle through the done
// cycle, both inclusive. With RO_CONT_EN defined, continuous mode is tested.
`timescale 1ns/1ps
module tb_ro_bank_meter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  sel;
    logic [15:0] gate_cycles;
`ifdef RO_CONT_EN
    logic        cont;
`endif
    logic        busy, done, overflow, osc_out;
    logic [15:0] count;
    logic        busy8, done8, overflow8, osc_out8;
    logic [7:0]  count8;

    int errors;
    int checks;
    int osc_toggles = 0;

    ro_bank_meter #(
        .NUM_RO(4), .STAGES(5), .DIV_LOG2(2), .GATE_W(16), .CNT_W(16), .SETTLE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .gate_cycles(gate_cycles),
`ifdef RO_CONT_EN
        .cont(cont),
`endif
        .busy(busy), .done(done), .count(count), .overflow(overflow), .osc_out(osc_out)
    );

    ro_bank_meter #(
        .NUM_RO(4), .STAGES(5), .DIV_LOG2(2), .GATE_W(16), .CNT_W(8), .SETTLE(4)
    ) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .gate_cycles(gate_cycles),
`ifdef RO_CONT_EN
        .cont(cont),
`endif
        .busy(busy8), .done(done8), .count(count8), .overflow(overflow8), .osc_out(osc_out8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(osc_out) osc_toggles++;

    // Issue one start and wait until both instances pulse done.
    task automatic run_measure(input logic [1:0] s, input logic [15:0] g, input int budget,
                               output int lat, output int lat8, output logic busy_acc);
        int n;
        lat = -1;
        lat8 = -1;
        busy_acc = 1'b0;
        @(negedge clk);
        sel = s;
        gate_cycles = g;
        start = 1'b1;
        n = 1;
        while (n < budget && (lat < 0 || lat8 < 0)) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 2) begin
                start = 1'b0;
                busy_acc = busy;
            end
            if (done && lat < 0) lat = n;
            if (done8 && lat8 < 0) lat8 = n;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        sel = 2'd0;
        gate_cycles = 16'd0;
`ifdef RO_CONT_EN
        cont = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (osc_out !== 1'b0 || osc_out8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_osc_out: got %b/%b want 0/0", osc_out, osc_out8); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_single();
        int lat, lat8;
        logic b;
        logic [15:0] held;
        run_measure(2'd0, 16'd1000, 1100, lat, lat8, b);
        checks++; if (b !== 1'b1) begin errors++; $display("[TB] FAIL busy_after_start: got %b want 1", b); end
        checks++; if (lat != 1006) begin errors++; $display("[TB] FAIL latency_1000: got %0d want 1006", lat); end
        checks++; if (count < 16'd499 || count > 16'd501) begin errors++; $display("[TB] FAIL count_1000: got %0d want 500+/-1", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_1000: got %b want 0", overflow); end
        held = count;
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL after_done: done=%b busy=%b want 0/0", done, busy); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (count !== held) begin errors++; $display("[TB] FAIL count_hold: got %0d want %0d", count, held); end
    endtask

    task automatic test_overflow();
        int lat, lat8;
        logic b;
        run_measure(2'd1, 16'd1000, 1100, lat, lat8, b);
        checks++; if (lat8 != 1006) begin errors++; $display("[TB] FAIL latency_cnt8: got %0d want 1006", lat8); end
        checks++; if (count8 !== 8'd255) begin errors++; $display("[TB] FAIL count_saturate: got %0d want 255", count8); end
        checks++; if (overflow8 !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set: got %b want 1", overflow8); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL overflow_wide: got %b want 0", overflow); end
        @(posedge clk);
    endtask

    task automatic test_zero_gate();
        int lat, lat8, snap, snap2;
        logic b;
        snap = osc_toggles;
        run_measure(2'd2, 16'd0, 50, lat, lat8, b);
        checks++; if (lat != 6) begin errors++; $display("[TB] FAIL latency_gate0: got %0d want 6", lat); end
        checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL count_gate0: got %0d want 0", count); end
        checks++; if (osc_toggles - snap < 8) begin errors++; $display("[TB] FAIL osc_in_arm: got %0d toggles want >=8", osc_toggles - snap); end
        snap2 = osc_toggles;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (osc_toggles != snap2) begin errors++; $display("[TB] FAIL osc_after_done: got %0d toggles want 0", osc_toggles - snap2); end
    endtask

    task automatic test_back_to_back();
        int n, lat, pulses;
        logic [15:0] at_done;
        lat = -1;
        pulses = 0;
        at_done = 16'd0;
        @(negedge clk);
        sel = 2'd0;
        gate_cycles = 16'd200;
        start = 1'b1;
        n = 1;
        while (n < 260) begin
            @(posedge clk);
            #1;
            n++;
            start = (n == 30);
            if (n == 30) begin
                sel = 2'd3;
                gate_cycles = 16'd5;
            end
            if (done) begin
                pulses++;
                if (lat < 0) begin
                    lat = n;
                    at_done = count;
                end
            end
        end
        start = 1'b0;
        checks++; if (lat != 206) begin errors++; $display("[TB] FAIL latency_b2b: got %0d want 206", lat); end
        checks++; if (pulses != 1) begin errors++; $display("[TB] FAIL done_pulses_b2b: got %0d want 1", pulses); end
        checks++; if (at_done < 16'd99 || at_done > 16'd101) begin errors++; $display("[TB] FAIL count_b2b: got %0d want 100+/-1", at_done); end
        checks++; if (busy !== 1'b0 || count !== at_done) begin errors++; $display("[TB] FAIL idle_hold_b2b: busy=%b count=%0d want 0/%0d", busy, count, at_done); end
    endtask

    task automatic test_reset_mid();
        int lat, lat8, pulses;
        logic b;
        @(negedge clk);
        sel = 2'd1;
        gate_cycles = 16'd500;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_flags: busy=%b done=%b want 0/0", busy, done); end
        checks++; if (count !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_count: got %0d want 0", count); end
        checks++; if (osc_out !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_osc: got %b want 0", osc_out); end
        pulses = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (600) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL no_done_after_abort: got %0d pulses want 0", pulses); end
        run_measure(2'd2, 16'd100, 200, lat, lat8, b);
        checks++; if (lat != 106) begin errors++; $display("[TB] FAIL latency_after_reset: got %0d want 106", lat); end
        checks++; if (count < 16'd49 || count > 16'd51) begin errors++; $display("[TB] FAIL count_after_reset: got %0d want 50+/-1", count); end
        @(posedge clk);
    endtask

`ifdef RO_CONT_EN
    task automatic test_continuous();
        int lat, lat8, n, pulses;
        logic b, busy_dropped;
        cont = 1'b1;
        busy_dropped = 1'b0;
        run_measure(2'd3, 16'd100, 200, lat, lat8, b);
        checks++; if (lat != 106) begin errors++; $display("[TB] FAIL cont_first_latency: got %0d want 106", lat); end
        checks++; if (count < 16'd49 || count > 16'd51) begin errors++; $display("[TB] FAIL cont_count_0: got %0d want 50+/-1", count); end
        for (int w = 1; w <= 2; w++) begin
            n = 1;
            do begin
                @(posedge clk);
                #1;
                n++;
                if (!busy) busy_dropped = 1'b1;
            end while (!done && n < 300);
            checks++; if (n != 102) begin errors++; $display("[TB] FAIL cont_period_%0d: got %0d want 102", w, n); end
            checks++; if (count < 16'd49 || count > 16'd51) begin errors++; $display("[TB] FAIL cont_count_%0d: got %0d want 50+/-1", w, count); end
        end
        checks++; if (busy_dropped) begin errors++; $display("[TB] FAIL cont_busy: got busy low between windows want 1"); end
        repeat (10) @(posedge clk);
        #1;
        cont = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 300);
        checks++; if (n != 91) begin errors++; $display("[TB] FAIL cont_stop_done: got %0d cycles want 91", n); end
        pulses = 0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_stop_idle: busy=%b want 0", busy); end
        repeat (150) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL cont_stop_pulses: got %0d want 0", pulses); end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_overflow();
        test_zero_gate();
        test_back_to_back();
        test_reset_mid();
`ifdef RO_CONT_EN
        test_continuous();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
